alu64: RTL and testbench

- 64-bit two's-complement arithmetic/logic unit for the SEQ Y86-64 execute stage.
- Performs ADD, SUB, AND or XOR on operands a and b, selected by the 2-bit code {c1,c0}.
- Computes the signed-overflow flag that execute latches into OF on OPq instructions.
- Result and overflow are registered: one clock of latency, synchronous active-low reset.

---
 rtl/alu64_pkg.sv | 14 +
 rtl/alu64_addsub.sv | 30 +++
 rtl/alu64.sv | 70 +++++++
 tb/tb_alu64.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu64_pkg.sv
// Shared definitions for the alu64 execute-stage ALU: op-select codes and default width.
package alu64_pkg;

  localparam int unsigned ALU64_WIDTH = 64;

  // Encoding matches Y86 OPq ifun[1:0], driven as {c1,c0}.
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu64_addsub.sv
// Combinational WIDTH-bit ripple-carry adder/subtractor built from full-adder cells.
module alu64_addsub #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] carry;

  // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
  assign b_eff    = sub ? ~b : b;
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = a[i] ^ b_eff[i] ^ carry[i];
    // The MSB cell has no carry-out; it is discarded.
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  // Signed overflow: like-signed effective operands producing an opposite-signed result.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu64.sv
// Y86-64 SEQ execute-stage ALU: ADD/SUB/AND/XOR with signed overflow, one cycle of latency.
module alu64
  import alu64_pkg::*;
#(
  parameter int unsigned WIDTH = ALU64_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             c0,
  input  logic             c1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] output_alu,
  output logic             bit_overflow,
  output logic             out_valid
);

  alu_op_e          op_sel;
  logic [WIDTH-1:0] addsub_sum;
  logic             addsub_ovf;
  logic [WIDTH-1:0] result_d, result_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  assign op_sel = alu_op_e'({c1, c0});

  alu64_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a        (a),
    .b        (b),
    .sub      (op_sel == ALU_SUB),
    .sum      (addsub_sum),
    .overflow (addsub_ovf)
  );

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unique case (op_sel)
      ALU_ADD, ALU_SUB: begin
        result_d = addsub_sum;
        ovf_d    = addsub_ovf;
      end
      ALU_AND: result_d = a & b;
      ALU_XOR: result_d = a ^ b;
    endcase
  end

  // Outputs hold their last result across idle cycles; only out_valid drops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign output_alu   = result_q;
  assign bit_overflow = ovf_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_alu64.sv
// Self-checking bench for alu64: directed boundary steps followed by randomized traffic vs a reference model.
module tb_alu64;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        c0, c1;
  logic [63:0] a, b;
  logic [63:0] output_alu;
  logic        bit_overflow;
  logic        out_valid;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference-model state
  logic [63:0] m_alu;
  logic        m_ovf;
  logic        m_valid;

  alu64 #(.WIDTH(64)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .c0           (c0),
    .c1           (c1),
    .a            (a),
    .b            (b),
    .output_alu   (output_alu),
    .bit_overflow (bit_overflow),
    .out_valid    (out_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] e_alu, input logic e_ovf,
                         input logic e_valid);
    chk({tag, ".alu"},   output_alu,          e_alu);
    chk({tag, ".ovf"},   {63'd0, bit_overflow}, {63'd0, e_ovf});
    chk({tag, ".valid"}, {63'd0, out_valid},    {63'd0, e_valid});
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic drive(input logic rst_n, input logic v, input logic [1:0] op,
                       input logic [63:0] x, input logic [63:0] y);
    reset_n  = rst_n;
    in_valid = v;
    c1       = op[1];
    c0       = op[0];
    a        = x;
    b        = y;
    @(posedge clock);
    #1;
  endtask

  // Reference: signed arithmetic on 65-bit sign-extended values; overflow iff the
  // true result does not fit in 64 signed bits.
  function automatic void model_op(input logic [1:0] op, input logic [63:0] x,
                                   input logic [63:0] y, output logic [63:0] res,
                                   output logic ovf);
    logic signed [64:0] wide;
    wide = '0;
    case (op)
      2'b00: wide = $signed({x[63], x}) + $signed({y[63], y});
      2'b01: wide = $signed({x[63], x}) - $signed({y[63], y});
      2'b10: wide = $signed({1'b0, x & y});
      default: wide = $signed({1'b0, x ^ y});
    endcase
    res = wide[63:0];
    ovf = (op[1] == 1'b0) && (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF || wide < -65'sh0_8000_0000_0000_0000);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return ALL1;
      3: return MAXP;
      4: return MINN;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] x, y, r;
    logic [1:0]  op;
    logic        v, rn, o;

    // Reset held with valid traffic present
    drive(1'b0, 1'b1, 2'b00, 64'd5, 64'd3);
    drive(1'b0, 1'b1, 2'b00, 64'd5, 64'd3);
    chk_all("reset", 64'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 64'd5, 64'd3);
    chk_all("post_reset_add", 64'd8, 1'b0, 1'b1);

    // Basic ops, back to back
    drive(1'b1, 1'b1, 2'b00, 64'h0F0F, 64'h00FF);
    chk_all("add", 64'h100E, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 64'h0F0F, 64'h00FF);
    chk_all("sub", 64'h0E10, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b10, 64'h0F0F, 64'h00FF);
    chk_all("and", 64'h000F, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b11, 64'h0F0F, 64'h00FF);
    chk_all("xor", 64'h0FF0, 1'b0, 1'b1);

    // ADD overflow boundaries, then a logic op must clear the flag
    drive(1'b1, 1'b1, 2'b00, MAXP, 64'd1);
    chk_all("add_maxp_plus1", MINN, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2'b11, ALL1, ALL1);
    chk_all("xor_clears_ovf", 64'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b00, ALL1, 64'd1);
    chk_all("add_m1_plus1", 64'd0, 1'b0, 1'b1);

    // SUB overflow boundaries
    drive(1'b1, 1'b1, 2'b01, MINN, 64'd1);
    chk_all("sub_minn_minus1", MAXP, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 64'd8, 64'd8);
    chk_all("sub_self", 64'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 64'd0, MINN);
    chk_all("sub_zero_minus_minn", MINN, 1'b1, 1'b1);

    // Hold on idle, then reset mid-stream
    drive(1'b1, 1'b1, 2'b01, 64'd100, 64'd8);
    chk_all("sub_100_8", 64'd92, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 64'd1234, 64'd5678);
    chk_all("idle_hold", 64'd92, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b00, MAXP, 64'd1);
    chk_all("pre_reset_ovf", MINN, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 2'b00, 64'd7, 64'd7);
    chk_all("reset_midstream", 64'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2'b10, ALL1, 64'h55);
    chk_all("first_after_reset", 64'h55, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    m_alu   = 64'h55;
    m_ovf   = 1'b0;
    m_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 31) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      x  = pick();
      y  = ($urandom_range(0, 7) == 0) ? x : pick();
      model_op(op, x, y, r, o);
      if (!rn) begin
        m_alu = '0; m_ovf = 1'b0; m_valid = 1'b0;
      end else begin
        m_valid = v;
        if (v) begin
          m_alu = r; m_ovf = o;
        end
      end
      drive(rn, v, op, x, y);
      chk_all($sformatf("rand%0d", i), m_alu, m_ovf, m_valid);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
